// File: rtl/spi_flash_read_ctrl.sv
// spi_flash_read_ctrl: single-lane mode-0 SPI master issuing serial-flash READ bursts onto a valid/ready byte stream.
// Optional build macro FAST_READ_EN selects FAST READ (0x0B) with 8 dummy SCK cycles before data.
module spi_flash_read_ctrl #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned ADDR_W  = 24
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_len,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_wp_n,
  output logic              spi_hold_n
);
  localparam int unsigned TX_W    = 8 + ADDR_W;
  localparam int unsigned BIT_W   = $clog2(ADDR_W);
  localparam int unsigned LEN_W   = 17;
  localparam int unsigned CNT_W   = 10;
  // CS stays high for the whole GAP plus the IDLE accept cycle.
  localparam int unsigned GAP_LEN = CS_GAP + CLK_DIV - 1;

`ifdef FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD, S_GAP
  } state_e;
`else
  localparam logic [7:0] OPCODE = 8'h03;
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_HOLD, S_GAP
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cs_n_q, cs_n_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              stall;

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      len_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      len_q       <= len_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, SCK generation, shifting and holding-register control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    len_d      = len_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q && !rd_ready;
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    tick       = (cnt_q == CNT_W'(CLK_DIV - 1));
    stall      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          tx_d    = {OPCODE, req_addr};
          mosi_d  = OPCODE[7];
          len_d   = LEN_W'(req_len) + LEN_W'(1);
        end
      end

      S_SETUP: begin
        if (tick) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          bit_d   = BIT_W'(7);
          state_d = S_CMD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef FAST_READ_EN
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
`else
      S_CMD, S_ADDR, S_DATA: begin
`endif
        // A new byte may not start while the holding register stays full.
        stall = (state_q == S_DATA) && !sck_q && (bit_q == BIT_W'(7)) &&
                rd_valid_q && !rd_ready;
        if (!tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!stall) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            if (state_q == S_DATA) begin
              rx_d = {rx_q[5:0], spi_miso};
              if (bit_q == '0) begin
                rd_data_d  = {rx_q, spi_miso};
                rd_valid_d = 1'b1;
                len_d      = len_q - LEN_W'(1);
              end
            end
          end else begin
            sck_d = 1'b0;
            if (state_q == S_CMD || state_q == S_ADDR) begin
              tx_d   = tx_q << 1;
              mosi_d = tx_q[TX_W-2];
            end
            if (bit_q != '0) begin
              bit_d = bit_q - BIT_W'(1);
            end else if (state_q == S_CMD) begin
              state_d = S_ADDR;
              bit_d   = BIT_W'(ADDR_W - 1);
            end else if (state_q == S_ADDR) begin
              mosi_d = 1'b0;
              bit_d  = BIT_W'(7);
`ifdef FAST_READ_EN
              state_d = S_DUMMY;
            end else if (state_q == S_DUMMY) begin
              bit_d   = BIT_W'(7);
              state_d = S_DATA;
`else
              state_d = S_DATA;
`endif
            end else if (len_q == '0) begin
              state_d = S_HOLD;
            end else begin
              bit_d = BIT_W'(7);
            end
          end
        end
      end

      S_HOLD: begin
        if (tick) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;
  assign spi_wp_n   = 1'b1;
  assign spi_hold_n = 1'b1;

endmodule
